rc_symbol_src: RTL and testbench

//  Symbol-rate source upstream of the raised-cosine polyphase interpolator.
//  - Generates the sample strobe (cke) and the symbol strobe (den) for that interpolator.
//  - Generates signed 16-bit PAM symbols (dout) from a PRBS9, a fixed pattern or a user value.
//  - den is aligned so the interpolator's phase counter wraps to 0 exactly when a new symbol shifts in.

---
 rtl/rc_symbol_src.sv | 158 +++++++++++++++
 tb/tb_rc_symbol_src.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_symbol_src.sv
// rc_symbol_src
// Symbol-rate source that feeds the raised-cosine polyphase interpolator.
// It produces the interpolator's sample strobe (cke) and symbol strobe (den).
// It also produces signed 16-bit PAM symbols (dout).
// Symbols come from a PRBS9, an alternating +/-amp pattern, or a user value.
// den is generated on the cke at which the interpolator's phase counter wraps.
// As a result, a new symbol enters the interpolator exactly on phase 0.

module rc_symbol_src #(
    parameter int OSR   = 10,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic [14:0]      amp,
    input  logic [15:0]      user_sym,
    output logic             cke,
    output logic             den,
    output logic [15:0]      dout
);

    localparam int             PH_W    = $clog2(OSR);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

    localparam logic [1:0] MODE_PAM2 = 2'd0;
    localparam logic [1:0] MODE_PAM4 = 2'd1;
    localparam logic [1:0] MODE_ALT  = 2'd2;

    logic [DIV_W-1:0] divcnt;
    logic             div_wrap;
    logic [PH_W-1:0]  phase;
    logic             primed;
    logic [8:0]       lfsr;
    logic             alt;
    logic             load;

    logic [8:0]       lfsr_step1;
    logic [8:0]       lfsr_step2;
    logic [14:0]      a3;
    logic [15:0]      amp_pos;
    logic [15:0]      amp_neg;
    logic [15:0]      a3_pos;
    logic [15:0]      a3_neg;
    logic [15:0]      next_sym;
    logic [8:0]       next_lfsr;
    logic             next_alt;

    // The divider wraps when divcnt reaches the live div value.
    // Using >= means a div lowered below the current count wraps at once, not after a 2^DIV_W roll-over.
    assign div_wrap = (divcnt >= div);

    // Sample-rate divider: registered cke one clk after the count reaches div.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divcnt <= '0;
            cke    <= 1'b0;
        end else if (!en) begin
            divcnt <= '0;
            cke    <= 1'b0;
        end else if (div_wrap) begin
            divcnt <= '0;
            cke    <= 1'b1;
        end else begin
            divcnt <= divcnt + DIV_W'(1);
            cke    <= 1'b0;
        end
    end

    // Phase counter: advances together with each generated cke.
    // den is raised on the same cke that takes phase from OSR-1 back to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
            den   <= 1'b0;
        end else if (!en) begin
            phase <= '0;
            den   <= 1'b0;
        end else if (div_wrap) begin
            den   <= (phase == PH_LAST);
            phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
        end else begin
            den   <= 1'b0;
        end
    end

    // A new symbol is loaded right after each den, and once on the first enabled clk to prime dout.
    assign load = !primed || den;

    // PRBS9 (x^9 + x^5 + 1): output is lfsr[8], and the register shifts left with new bit lfsr[8]^lfsr[4].
    // PAM4 consumes two bits per symbol, so a second step is precomputed here.
    always_comb begin
        lfsr_step1 = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        lfsr_step2 = {lfsr_step1[7:0], lfsr_step1[8] ^ lfsr_step1[4]};
    end

    // Symbol magnitudes: a3 is floor(amp * 21845 / 65536), i.e. roughly amp/3.
    // amp is at most 32767, so negation never overflows 16 bits.
    assign a3      = 15'(({16'd0, amp} * 31'd21845) >> 16);
    assign amp_pos = {1'b0, amp};
    assign amp_neg = -amp_pos;
    assign a3_pos  = {1'b0, a3};
    assign a3_neg  = -a3_pos;

    // Next-symbol selection from mode.
    // Only the PRBS modes advance the lfsr; only the alternating mode toggles alt.
    always_comb begin
        next_sym  = dout;
        next_lfsr = lfsr;
        next_alt  = alt;
        case (mode)
            MODE_PAM2: begin
                next_sym  = lfsr[8] ? amp_pos : amp_neg;
                next_lfsr = lfsr_step1;
            end
            MODE_PAM4: begin
                // Gray mapping, first PRBS bit is the MSB
                case ({lfsr[8], lfsr_step1[8]})
                    2'b00:   next_sym = amp_neg;
                    2'b01:   next_sym = a3_neg;
                    2'b11:   next_sym = a3_pos;
                    default: next_sym = amp_pos;
                endcase
                next_lfsr = lfsr_step2;
            end
            MODE_ALT: begin
                next_sym = alt ? amp_neg : amp_pos;
                next_alt = ~alt;
            end
            default: begin
                next_sym = user_sym;
            end
        endcase
    end

    // Symbol state: dout, lfsr and alt hold while disabled.
    // primed is cleared so that re-enabling loads the next symbol in the sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout   <= '0;
            lfsr   <= 9'h1FF;
            alt    <= 1'b0;
            primed <= 1'b0;
        end else if (!en) begin
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
            if (load) begin
                dout <= next_sym;
                lfsr <= next_lfsr;
                alt  <= next_alt;
            end
        end
    end

endmodule

// File: tb/tb_rc_symbol_src.sv
// tb_rc_symbol_src
// Randomized scoreboard bench for rc_symbol_src.
// The stimulus process pushes the symbol the DUT is about to load.
// The monitor pops that symbol when den presents it, and checks strobe timing.

module tb_rc_symbol_src;

    localparam int OSR   = 10;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div;
    logic [1:0]       mode;
    logic [14:0]      amp;
    logic [15:0]      user_sym;
    logic             cke;
    logic             den;
    logic [15:0]      dout;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    // Reference model state: the PRBS9 bit stream as a plain array plus a read pointer
    bit prbs_bits[511];
    int bit_ptr = 0;
    bit alt_ref = 1'b0;

    // Monitor bookkeeping
    int gap       = 0;
    int cke_count = 0;

    rc_symbol_src #(.OSR(OSR), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div      (div),
        .mode     (mode),
        .amp      (amp),
        .user_sym (user_sym),
        .cke      (cke),
        .den      (den),
        .dout     (dout)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Bit sequence of x^9+x^5+1 starting from all ones: o[k] = o[k-9] ^ o[k-5]
    function automatic void build_prbs();
        for (int i = 0; i < 511; i++) begin
            if (i < 9) prbs_bits[i] = 1'b1;
            else       prbs_bits[i] = prbs_bits[i-9] ^ prbs_bits[i-5];
        end
    endfunction

    function automatic bit take_bit();
        bit b;
        b       = prbs_bits[bit_ptr];
        bit_ptr = (bit_ptr + 1) % 511;
        return b;
    endfunction

    // Symbol the DUT will load given the inputs currently applied
    function automatic logic [15:0] model_load();
        int a;
        int a3;
        int v;
        bit hi;
        bit lo;
        a  = int'(amp);
        a3 = (a * 21845) / 65536;
        v  = 0;
        case (mode)
            2'd0: v = take_bit() ? a : -a;
            2'd1: begin
                hi = take_bit();
                lo = take_bit();
                if (!hi && !lo)     v = -a;
                else if (!hi && lo) v = -a3;
                else if (hi && lo)  v = a3;
                else                v = a;
            end
            2'd2: begin
                v       = alt_ref ? -a : a;
                alt_ref = ~alt_ref;
            end
            default: v = int'($signed(user_sym));
        endcase
        return v[15:0];
    endfunction

    // Monitor: strobe timing every clk, symbol comparison whenever den is high
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                gap       = 0;
                cke_count = 0;
            end else if (!en) begin
                check_output("idle_cke", int'(cke), 0);
                check_output("idle_den", int'(den), 0);
                gap       = 0;
                cke_count = 0;
            end else begin
                gap++;
                if (cke) begin
                    check_output("cke_period", gap, int'(div) + 1);
                    gap = 0;
                    cke_count++;
                end else if (gap > int'(div) + 1) begin
                    check_output("cke_missing", gap, int'(div) + 1);
                    gap = 0;
                end
                if (den) begin
                    check_output("den_on_cke", int'(cke), 1);
                    check_output("den_spacing", cke_count, OSR);
                    cke_count = 0;
                    check_output("sb_has_entry", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0)
                        check_output("symbol", int'($signed(dout)), int'($signed(exp_q.pop_front())));
                end else if (cke_count > OSR) begin
                    check_output("den_missing", cke_count, OSR);
                    cke_count = 0;
                end
            end
        end
    end

    // Wait (bounded) for den at a falling edge
    task automatic wait_den(output bit ok);
        int limit;
        limit = 3 * OSR * (int'(div) + 1) + 10;
        ok    = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (den) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("den_timeout", int'(ok), 1);
    endtask

    // After each den, the DUT reloads on the next edge, so the expected symbol is pushed now
    task automatic run_symbols(input int n);
        bit ok;
        for (int k = 0; k < n; k++) begin
            wait_den(ok);
            if (!ok) return;
            exp_q.push_back(model_load());
        end
    endtask

    // Raising en primes dout on the next edge
    task automatic start_run();
        @(negedge clk);
        en = 1'b1;
        exp_q.push_back(model_load());
    endtask

    // Drop en offset clks after the last den.
    // The pending symbol is never presented, and dout must hold it.
    task automatic stop_run(input int offset, input int hold_clks);
        logic [15:0] held;
        repeat (offset) @(negedge clk);
        en = 1'b0;
        check_output("sb_pending", exp_q.size(), 1);
        held = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
        exp_q.delete();
        for (int i = 0; i < hold_clks; i++) begin
            @(negedge clk);
            check_output("hold_dout", int'($signed(dout)), int'($signed(held)));
        end
    endtask

    // Asynchronous reset between clock edges; outputs must clear without waiting for a clk
    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        en  = 1'b0;
        #1;
        check_output("rst_cke", int'(cke), 0);
        check_output("rst_den", int'(den), 0);
        check_output("rst_dout", int'(dout), 0);
        exp_q.delete();
        bit_ptr = 0;
        alt_ref = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        div      = '0;
        mode     = 2'd0;
        amp      = 15'd0;
        user_sym = 16'd0;
        build_prbs();

        // Reset, then idle with en=0
        #3 rst = 1'b0;
        #1;
        check_output("init_cke", int'(cke), 0);
        check_output("init_den", int'(den), 0);
        check_output("init_dout", int'(dout), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_output("idle_dout", int'(dout), 0);
        end

        // PAM2 with cke on every clk
        div  = '0;
        mode = 2'd0;
        amp  = 15'd1000;
        start_run();
        run_symbols(12);
        stop_run(1, 3);

        // Divided sample rate
        div = DIV_W'(4);
        start_run();
        run_symbols(5);
        stop_run(1, 3);

        // PAM4 from a fresh PRBS state over a full period and more
        apply_reset();
        div  = '0;
        mode = 2'd1;
        amp  = 15'd30000;
        start_run();
        run_symbols(512);
        stop_run(1, 2);

        // Alternating pattern, then a switch to the user symbol in the middle of a symbol
        mode = 2'd2;
        amp  = 15'd500;
        start_run();
        run_symbols(4);
        repeat (2) @(negedge clk);
        mode     = 2'd3;
        user_sym = 16'hFB2E;
        run_symbols(3);

        // Back to PRBS, then disable for 7 clk, timed so that a pending den is suppressed
        repeat (2) @(negedge clk);
        mode = 2'd0;
        amp  = 15'd1000;
        run_symbols(3);
        stop_run(OSR - 1, 7);
        start_run();
        run_symbols(5);

        // Random configuration changes and random disable windows
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                stop_run(int'($urandom_range(1, OSR * (int'(div) + 1) - 1)),
                         int'($urandom_range(1, 6)));
                div = DIV_W'($urandom_range(0, 3));
                start_run();
            end else begin
                repeat (int'($urandom_range(1, 2))) @(negedge clk);
                mode     = 2'($urandom_range(0, 3));
                amp      = 15'($urandom_range(0, 32767));
                user_sym = 16'($urandom());
            end
            run_symbols(int'($urandom_range(1, 3)));
        end

        // Asynchronous reset while running
        apply_reset();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
